miss_fill_arbiter: RTL and testbench
====================================

// Module: miss_fill_arbiter
// PURPOSE
//   Sits between the I/D cache controllers and the multi-cycle main memory.
//   Arbitrates I-miss, D-miss and D-side write-through requests onto the single memory port.
//   For a miss, streams the 8 words of the 16-byte block into the requesting cache's data
//   array, then issues one tag write.
//   Owns all memory address/enable/write generation for the cache subsystem.
// PARAMETERS
//   MEM_LATENCY      4   cycles from a read issue to its mem_data_vld (memory model; block counts valids)
//   WORDS_PER_BLOCK  8   16-bit words per cache block; the word counters are clog2 = 3 bits
// PORTS
//   clk          in   1   rising-edge clock
//   rst          in   1   asynchronous, active-high reset
//   imiss_req    in   1   I-cache miss; level, held until itag_we is seen
//   imiss_addr   in   16  I-side miss byte address
//   dmiss_req    in   1   D-cache miss; level, held until dtag_we is seen
//   dmiss_addr   in   16  D-side miss byte address
//   dwt_req      in   1   D-side store write-through request; level, held until dwt_ack
//   dwt_addr     in   16  store byte address
//   dwt_data     in   16  store data
//   mem_data_vld in   1   memory read data valid
//   mem_rdata    in   16  memory read data
//   mem_addr     out  16  memory address
//   mem_wdata    out  16  memory write data
//   mem_enable   out  1   memory access strobe
//   mem_wr       out  1   1 = write, 0 = read; meaningful only with mem_enable
//   fill_word    out  16  word to write into the cache data array (= mem_rdata)
//   fill_sel     out  8   one-hot word select within the block
//   ifill_we     out  1   I-cache data-array write enable
//   dfill_we     out  1   D-cache data-array write enable
//   itag_we      out  1   I-cache tag write strobe
//   dtag_we      out  1   D-cache tag write strobe
//   fill_tag     out  6   tag to write = latched addr[15:10]
//   fill_index   out  6   set index = latched addr[9:4]
//   dwt_ack      out  1   write-through accepted this cycle
//   busy         out  1   arbiter occupied; caches stall
// BEHAVIOUR
//   Reset: state=IDLE, all counters 0, every output 0. Reset mid-operation abandons the fill:
//     no tag write, so the partial block stays invalid. Requesters re-request after reset.
//   States: IDLE, WRITE, ISSUE, COLLECT, DONE.
//   IDLE: accept with priority dmiss_req > dwt_req > imiss_req. The priority gives write-allocate:
//     a store miss is filled before it is written through.
//     On accept, latch the address and the side (I/D); requests arriving later wait in IDLE.
//     mem_data_vld in IDLE is ignored.
//   WRITE (1 cycle): mem_enable=1, mem_wr=1, mem_addr=dwt_addr, mem_wdata=dwt_data, dwt_ack=1.
//     Then -> IDLE.
//   ISSUE (8 cycles): mem_enable=1, mem_wr=0, mem_addr={addr[15:4],icnt,1'b0}, icnt 0..7.
//     After icnt=7 -> COLLECT if rcnt<8; if the 8th valid arrives in the same cycle -> DONE.
//   Collect (ISSUE or COLLECT): on each mem_data_vld, fill_word=mem_rdata, fill_sel=onehot(rcnt),
//     and the selected side's fill_we=1, all in the same cycle; then rcnt++.
//     After the 8th valid -> DONE.
//   DONE (1 cycle): the selected side's tag_we=1, with fill_tag/fill_index from the latched address.
//     Then -> IDLE.
//   busy = (state != IDLE). The grant is made in IDLE and busy rises the next cycle.
//   Fill latency with MEM_LATENCY=4 and accept at cycle N:
//     issues N+1..N+8; valids N+5..N+12; tag_we at N+13; back in IDLE at N+14.
//   Address bit 0 is always 0 on reads. Word counters wrap within 3 bits and never cross the
//     block boundary.
//   A request still high in the cycle after DONE is a new miss and re-arbitrates normally.
//   fill_tag/fill_index hold their value outside DONE; fill_sel is 0 when no fill_we is high.
// TESTING
//   1 I-miss at 0x1234, memory returns word k = 0x1230+2k -> ifill_we x8 with fill_sel 01..80;
//     itag_we at N+13 with fill_tag=0x04, fill_index=0x23.
//   2 imiss_req and dmiss_req rise together -> D block filled first (dtag_we at N+13);
//     the I fill issues from N+15; no fill_we goes to the wrong side.
//   3 dwt_req addr 0x0042 data 0xBEEF in IDLE -> one cycle of mem_enable=1, mem_wr=1,
//     dwt_ack=1; busy=1 for exactly 1 cycle.
//   4 dwt_req raised mid I-fill -> no dwt_ack until after itag_we; then WRITE accepted.
//   5 rst asserted after the 3rd valid of a fill -> all outputs 0 immediately (async);
//     no tag_we; a new I-miss afterwards refills from word 0.
//   6 stray mem_data_vld pulses in IDLE -> no fill_we, state stays IDLE.

Source files
------------

// File: rtl/miss_fill_arbiter.sv
// ---------------------------------------------------------------------------
// miss_fill_arbiter
//
// Purpose:
//   Owns the single main-memory port of the I/D cache subsystem. Arbitrates
//   I-cache misses, D-cache misses and D-side store write-throughs. For a
//   miss it issues eight word reads of the 16-byte block, streams every
//   returned word into the requesting cache's data array, and then issues a
//   single tag write for that cache. A write-through is one memory write cycle
//   that is acknowledged back to the D side.
//
//   Grant priority in IDLE is dmiss > dwt > imiss. A store that misses is
//   therefore allocated (filled) before its write-through is performed.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset
//   imiss_req     I-cache miss (level, held until itag_we)
//   imiss_addr    I-side miss byte address
//   dmiss_req     D-cache miss (level, held until dtag_we)
//   dmiss_addr    D-side miss byte address
//   dwt_req       D-side write-through (level, held until dwt_ack)
//   dwt_addr      write-through byte address
//   dwt_data      write-through data
//   mem_data_vld  memory read data valid
//   mem_rdata     memory read data
//   mem_addr      memory address
//   mem_wdata     memory write data
//   mem_enable    memory access strobe
//   mem_wr        1 = write, 0 = read (qualified by mem_enable)
//   fill_word     word written into the cache data array
//   fill_sel      one-hot word select within the block (0 when no fill)
//   ifill_we      I-cache data-array write enable
//   dfill_we      D-cache data-array write enable
//   itag_we       I-cache tag write strobe
//   dtag_we       D-cache tag write strobe
//   fill_tag      tag of the filled block (latched addr[15:10])
//   fill_index    set index of the filled block (latched addr[9:4])
//   dwt_ack       write-through performed this cycle
//   busy          arbiter occupied; caches stall
//
// States:
//   state     | meaning
//   S_IDLE    | waiting for a request; arbitrates dmiss > dwt > imiss
//   S_WRITE   | one memory write cycle for a write-through, dwt_ack high
//   S_ISSUE   | issuing the 8 word reads of the block, collecting early data
//   S_COLLECT | all reads issued, collecting the remaining read data
//   S_DONE    | one tag write cycle for the filled side
// ---------------------------------------------------------------------------
module miss_fill_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        imiss_req,
  input  logic [15:0] imiss_addr,
  input  logic        dmiss_req,
  input  logic [15:0] dmiss_addr,
  input  logic        dwt_req,
  input  logic [15:0] dwt_addr,
  input  logic [15:0] dwt_data,
  input  logic        mem_data_vld,
  input  logic [15:0] mem_rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] fill_word,
  output logic [7:0]  fill_sel,
  output logic        ifill_we,
  output logic        dfill_we,
  output logic        itag_we,
  output logic        dtag_we,
  output logic [5:0]  fill_tag,
  output logic [5:0]  fill_index,
  output logic        dwt_ack,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_ISSUE   = 3'd2,
    S_COLLECT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t      state;
  logic        side_d;     // 1 = current fill belongs to the D cache
  logic [15:4] blk_addr;   // block address of the current fill
  logic [2:0]  icnt;       // word currently being issued
  logic [2:0]  rcnt;       // next word slot to receive data
  logic        rdone;      // all 8 words received before the last issue

  logic        collecting;
  logic        fill_hit;
  logic        last_vld;
  logic [2:0]  icnt_nxt;

  // The byte/word offset of a miss address is irrelevant: the whole block is
  // always fetched starting at word 0.
  logic        unused_offset_bits;
  assign unused_offset_bits = ^{imiss_addr[3:0], dmiss_addr[3:0]};

  assign collecting = (state == S_ISSUE) || (state == S_COLLECT);
  // Once all 8 words are in, further valids (possible only with a memory
  // faster than the issue rate) must not overwrite word 0 again.
  assign fill_hit   = collecting && mem_data_vld && !rdone;
  assign last_vld   = fill_hit && (rcnt == 3'd7);
  assign icnt_nxt   = icnt + 3'd1;

  // Data-array writes happen in the same cycle as the returning data, so
  // these are decoded from the live valid rather than registered.
  assign ifill_we   = fill_hit && !side_d;
  assign dfill_we   = fill_hit &&  side_d;
  assign fill_word  = fill_hit ? mem_rdata : 16'h0000;
  assign fill_sel   = fill_hit ? (8'b0000_0001 << rcnt) : 8'h00;

  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      side_d     <= 1'b0;
      blk_addr   <= '0;
      icnt       <= 3'd0;
      rcnt       <= 3'd0;
      rdone      <= 1'b0;
      mem_addr   <= 16'h0000;
      mem_wdata  <= 16'h0000;
      mem_enable <= 1'b0;
      mem_wr     <= 1'b0;
      itag_we    <= 1'b0;
      dtag_we    <= 1'b0;
      fill_tag   <= 6'h00;
      fill_index <= 6'h00;
      dwt_ack    <= 1'b0;
    end else begin
      dwt_ack <= 1'b0;
      itag_we <= 1'b0;
      dtag_we <= 1'b0;

      if (fill_hit) begin
        rcnt <= rcnt + 3'd1;
      end

      case (state)
        S_IDLE: begin
          if (dmiss_req) begin
            side_d     <= 1'b1;
            blk_addr   <= dmiss_addr[15:4];
            mem_addr   <= {dmiss_addr[15:4], 4'h0};
            mem_enable <= 1'b1;
            mem_wr     <= 1'b0;
            icnt       <= 3'd0;
            rcnt       <= 3'd0;
            rdone      <= 1'b0;
            state      <= S_ISSUE;
          end else if (dwt_req) begin
            mem_addr   <= dwt_addr;
            mem_wdata  <= dwt_data;
            mem_enable <= 1'b1;
            mem_wr     <= 1'b1;
            dwt_ack    <= 1'b1;
            state      <= S_WRITE;
          end else if (imiss_req) begin
            side_d     <= 1'b0;
            blk_addr   <= imiss_addr[15:4];
            mem_addr   <= {imiss_addr[15:4], 4'h0};
            mem_enable <= 1'b1;
            mem_wr     <= 1'b0;
            icnt       <= 3'd0;
            rcnt       <= 3'd0;
            rdone      <= 1'b0;
            state      <= S_ISSUE;
          end
        end

        S_WRITE: begin
          mem_addr   <= 16'h0000;
          mem_wdata  <= 16'h0000;
          mem_enable <= 1'b0;
          mem_wr     <= 1'b0;
          state      <= S_IDLE;
        end

        S_ISSUE: begin
          if (icnt == 3'd7) begin
            mem_addr   <= 16'h0000;
            mem_enable <= 1'b0;
            if (rdone || last_vld) begin
              itag_we    <= !side_d;
              dtag_we    <= side_d;
              fill_tag   <= blk_addr[15:10];
              fill_index <= blk_addr[9:4];
              state      <= S_DONE;
            end else begin
              state <= S_COLLECT;
            end
          end else begin
            icnt     <= icnt_nxt;
            mem_addr <= {blk_addr, icnt_nxt, 1'b0};
            if (last_vld) begin
              rdone <= 1'b1;
            end
          end
        end

        S_COLLECT: begin
          if (last_vld) begin
            itag_we    <= !side_d;
            dtag_we    <= side_d;
            fill_tag   <= blk_addr[15:10];
            fill_index <= blk_addr[9:4];
            state      <= S_DONE;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_miss_fill_arbiter.sv
module tb_miss_fill_arbiter;

  localparam int MEM_LATENCY = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imiss_req = 1'b0;
  logic [15:0] imiss_addr = 16'h0000;
  logic        dmiss_req = 1'b0;
  logic [15:0] dmiss_addr = 16'h0000;
  logic        dwt_req = 1'b0;
  logic [15:0] dwt_addr = 16'h0000;
  logic [15:0] dwt_data = 16'h0000;
  logic        mem_data_vld = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] fill_word;
  logic [7:0]  fill_sel;
  logic        ifill_we;
  logic        dfill_we;
  logic        itag_we;
  logic        dtag_we;
  logic [5:0]  fill_tag;
  logic [5:0]  fill_index;
  logic        dwt_ack;
  logic        busy;

  miss_fill_arbiter dut (
    .clk(clk), .rst(rst),
    .imiss_req(imiss_req), .imiss_addr(imiss_addr),
    .dmiss_req(dmiss_req), .dmiss_addr(dmiss_addr),
    .dwt_req(dwt_req), .dwt_addr(dwt_addr), .dwt_data(dwt_data),
    .mem_data_vld(mem_data_vld), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_enable(mem_enable), .mem_wr(mem_wr),
    .fill_word(fill_word), .fill_sel(fill_sel),
    .ifill_we(ifill_we), .dfill_we(dfill_we),
    .itag_we(itag_we), .dtag_we(dtag_we),
    .fill_tag(fill_tag), .fill_index(fill_index),
    .dwt_ack(dwt_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  // kind: 0 = data-array fill word, 1 = tag write, 2 = write-through
  typedef struct {
    int          kind;
    logic        side;
    logic [7:0]  sel;
    logic [15:0] data;
    logic [15:0] addr;
    logic [5:0]  tag;
    logic [5:0]  idx;
    int          cyc;
  } ev_t;

  ev_t         exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [15:0] salt = 16'h0000;
  logic        inject = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Memory model: word contents are the word address xor salt; each read
  // issued in cycle t returns its data valid in cycle t+MEM_LATENCY.
  logic        pv [MEM_LATENCY];
  logic [15:0] pa [MEM_LATENCY];
  logic        cap_en;
  logic [15:0] cap_addr;
  initial begin
    for (int i = 0; i < MEM_LATENCY; i++) begin
      pv[i] = 1'b0;
      pa[i] = 16'h0000;
    end
    forever begin
      @(negedge clk);
      cap_en   = mem_enable & ~mem_wr;
      cap_addr = mem_addr;
      @(posedge clk);
      #1;
      for (int i = MEM_LATENCY - 1; i > 0; i--) begin
        pv[i] = pv[i-1];
        pa[i] = pa[i-1];
      end
      pv[0] = cap_en;
      pa[0] = cap_addr;
      if (pv[MEM_LATENCY-1]) begin
        mem_data_vld = 1'b1;
        mem_rdata    = pa[MEM_LATENCY-1] ^ salt;
      end else begin
        mem_data_vld = inject;
        mem_rdata    = 16'($urandom);
      end
    end
  end

  // Reference model: a granted miss at cycle a produces word k of the block
  // at a+5+k and the tag write at a+13; a granted write-through at cycle a
  // produces the memory write at a+1.
  task automatic push_miss(input logic side, input logic [15:0] addr, input int a);
    ev_t e;
    logic [15:0] base;
    base = addr & 16'hFFF0;
    for (int k = 0; k < 8; k++) begin
      e = '{kind: 0, side: side, sel: 8'(1 << k), data: (base + 16'(2 * k)) ^ salt,
            addr: 16'h0, tag: 6'h0, idx: 6'h0, cyc: a + 5 + k};
      exp_q.push_back(e);
    end
    e = '{kind: 1, side: side, sel: 8'h0, data: 16'h0, addr: 16'h0,
          tag: addr[15:10], idx: addr[9:4], cyc: a + 13};
    exp_q.push_back(e);
  endtask

  task automatic push_write(input logic [15:0] addr, input logic [15:0] data, input int a);
    ev_t e;
    e = '{kind: 2, side: 1'b1, sel: 8'h0, data: data, addr: addr,
          tag: 6'h0, idx: 6'h0, cyc: a + 1};
    exp_q.push_back(e);
  endtask

  task automatic check_event(input int kind);
    ev_t e;
    chk("event_expected", 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    chk("event_kind", 64'(kind), 64'(e.kind));
    chk("event_cycle", 64'(cyc), 64'(e.cyc));
    case (kind)
      0: chk("fill", {ifill_we, dfill_we, fill_sel, fill_word},
                     {~e.side, e.side, e.sel, e.data});
      1: chk("tag", {itag_we, dtag_we, fill_tag, fill_index},
                    {~e.side, e.side, e.tag, e.idx});
      default: chk("write_through", {mem_enable, mem_wr, dwt_ack, mem_addr, mem_wdata},
                                    {3'b111, e.addr, e.data});
    endcase
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (mem_enable && !mem_wr) chk("read_addr_lsb", 64'(mem_addr[0]), 64'd0);
      if (ifill_we || dfill_we) check_event(0);
      if (itag_we || dtag_we) check_event(1);
      if (dwt_ack || (mem_enable && mem_wr)) check_event(2);
    end
  end

  // Requesters drop their level request once served.
  task automatic tick();
    @(negedge clk);
    if (itag_we) imiss_req = 1'b0;
    if (dtag_we) dmiss_req = 1'b0;
    if (dwt_ack) dwt_req = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 300; n++) begin
      tick();
      if (exp_q.size() == 0 && !busy && !imiss_req && !dmiss_req && !dwt_req) return;
    end
    chk("idle_reached", {exp_q.size() == 0, busy, imiss_req, dmiss_req, dwt_req}, 64'b10000);
    exp_q.delete();
    imiss_req = 1'b0;
    dmiss_req = 1'b0;
    dwt_req   = 1'b0;
  endtask

  // Raise a set of requests together (order of service is D, W, I), or an
  // I-miss followed later by a write-through that must wait for it.
  task automatic run_group(input bit d, input bit w, input bit i, input bit late_w,
                           input logic [15:0] da, input logic [15:0] ia,
                           input logic [15:0] wa, input logic [15:0] wd);
    int a;
    wait_idle();
    a = cyc;
    if (d) begin push_miss(1'b1, da, a); a += 14; end
    if (w && !late_w) begin push_write(wa, wd, a); a += 2; end
    if (i) begin push_miss(1'b0, ia, a); a += 14; end
    dmiss_addr = da;
    imiss_addr = ia;
    dwt_addr   = wa;
    dwt_data   = wd;
    dmiss_req  = d;
    imiss_req  = i;
    dwt_req    = w && !late_w;
    if (late_w) begin
      repeat ($urandom_range(2, 10)) tick();
      push_write(wa, wd, a);
      dwt_req = 1'b1;
    end
    wait_idle();
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_data"}, {mem_addr, mem_wdata, fill_word}, 64'd0);
    chk({name, "_ctrl"}, {mem_enable, mem_wr, fill_sel, ifill_we, dfill_we, itag_we, dtag_we,
                          fill_tag, fill_index, dwt_ack, busy}, 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int mode;
    logic [15:0] ra;

    repeat (3) tick();
    chk_all_zero("reset_state");
    rst = 1'b0;

    // I-miss at 0x1234, memory word k = 0x1230 + 2k
    salt = 16'h0000;
    run_group(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h1234, 16'h0, 16'h0);

    // simultaneous I and D miss: D first
    salt = 16'h5A5A;
    run_group(1'b1, 1'b0, 1'b1, 1'b0, 16'hC3F8, 16'h0A16, 16'h0, 16'h0);

    // single write-through, busy for exactly one cycle
    wait_idle();
    a = cyc;
    push_write(16'h0042, 16'hBEEF, a);
    dwt_addr = 16'h0042;
    dwt_data = 16'hBEEF;
    dwt_req  = 1'b1;
    chk("busy_before_write", 64'(busy), 64'd0);
    tick();
    chk("busy_during_write", 64'(busy), 64'd1);
    tick();
    chk("busy_after_write", 64'(busy), 64'd0);

    // write-through raised in the middle of an I fill
    run_group(1'b0, 1'b1, 1'b0 | 1'b1, 1'b1, 16'h0, 16'h7F20, 16'h1110, 16'h2222);

    // reset after the third valid of a fill
    wait_idle();
    a  = cyc;
    ra = 16'h9ABC;
    push_miss(1'b0, ra, a);
    imiss_addr = ra;
    imiss_req  = 1'b1;
    repeat (7) tick();
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_reset");
    exp_q.delete();
    imiss_req = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (8) tick();
    run_group(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, ra, 16'h0, 16'h0);

    // stray valids while idle
    wait_idle();
    inject = 1'b1;
    repeat (6) begin
      tick();
      chk("stray_busy", 64'(busy), 64'd0);
      chk("stray_fill", {ifill_we, dfill_we, fill_sel}, 64'd0);
    end
    inject = 1'b0;

    // randomized request mixes
    for (int n = 0; n < 20; n++) begin
      salt = 16'($urandom);
      mode = $urandom_range(0, 7);
      if (mode == 7) begin
        run_group(1'b0, 1'b1, 1'b1, 1'b1, 16'h0, 16'($urandom), 16'($urandom), 16'($urandom));
      end else begin
        if (mode == 0) mode = 5;
        run_group(mode[2], mode[1], mode[0], 1'b0,
                  16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      end
    end

    wait_idle();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
